// File: rtl/gb_instr_issuer.sv
// Instruction issuer: buffers opcode bytes while idle, then replays them to the
// processor with an optional idle gap, capturing the probe after each issue.
module gb_instr_issuer #(
    parameter int DEPTH = 16,
    parameter int GAP   = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_valid,
    input  logic [7:0]               load_data,
    output logic                     load_ready,
    input  logic                     start,
    output logic                     valid,
    output logic [7:0]               instruction,
    input  logic [7:0]               probe,
    output logic                     result_valid,
    output logic [7:0]               result_probe,
    output logic [$clog2(DEPTH):0]   issued_cnt,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [3:0]    GAP_RELOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   issued_cnt_q, issued_cnt_d;
    logic [3:0]      gap_cnt_q, gap_cnt_d;
    logic            result_valid_q, result_valid_d;
    logic [7:0]      result_probe_q, result_probe_d;

    logic            mem_we;
    logic            load_beat;
    logic            can_load;
    logic [7:0]      mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            issued_cnt_q   <= '0;
            gap_cnt_q      <= '0;
            result_valid_q <= 1'b0;
            result_probe_q <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            issued_cnt_q   <= issued_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            result_valid_q <= result_valid_d;
            result_probe_q <= result_probe_d;
        end
    end

    // Storage is deliberately unreset; count and pointers define what is valid.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= load_data;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        issued_cnt_d   = issued_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        result_valid_d = 1'b0;
        result_probe_d = result_probe_q;
        mem_we         = 1'b0;
        load_beat      = 1'b0;
        can_load       = (state_q == ST_IDLE) && (count_q != DEPTH_C);

        case (state_q)
            ST_IDLE: begin
                if (load_valid && can_load) begin
                    load_beat = 1'b1;
                    mem_we    = 1'b1;
                    wr_ptr_d  = wr_ptr_q + AW'(1);
                    count_d   = count_q + CW'(1);
                end
                // A same-cycle load counts toward the run it starts.
                if (start && ((count_q != '0) || load_beat)) begin
                    state_d      = ST_ISSUE;
                    issued_cnt_d = '0;
                end
            end
            ST_ISSUE: begin
                rd_ptr_d       = rd_ptr_q + AW'(1);
                issued_cnt_d   = issued_cnt_q + CW'(1);
                count_d        = count_q - CW'(1);
                result_valid_d = 1'b1;
                result_probe_d = probe;
                if (count_q == CW'(1)) begin
                    state_d = ST_DRAIN;
                end else if (GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_RELOAD;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign load_ready   = can_load;
    assign valid        = (state_q == ST_ISSUE);
    assign instruction  = valid ? mem[rd_ptr_q] : 8'h00;
    assign busy         = (state_q == ST_ISSUE) || (state_q == ST_GAP);
    assign done         = (state_q == ST_DRAIN);
    assign result_valid = result_valid_q;
    assign result_probe = result_probe_q;
    assign issued_cnt   = issued_cnt_q;

endmodule

// File: tb/tb_gb_instr_issuer.sv
// Directed bench for gb_instr_issuer: one instance with no gap, one with GAP=2,
// both driven by the same stimulus.
module tb_gb_instr_issuer;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic       start;
    logic [7:0] probe;

    logic       load_ready,   load_ready_g;
    logic       valid,        valid_g;
    logic [7:0] instruction,  instruction_g;
    logic       result_valid, result_valid_g;
    logic [7:0] result_probe, result_probe_g;
    logic [4:0] issued_cnt,   issued_cnt_g;
    logic       busy,         busy_g;
    logic       done,         done_g;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    gb_instr_issuer #(.DEPTH(16), .GAP(0)) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .start(start), .valid(valid), .instruction(instruction), .probe(probe),
        .result_valid(result_valid), .result_probe(result_probe),
        .issued_cnt(issued_cnt), .busy(busy), .done(done)
    );

    gb_instr_issuer #(.DEPTH(16), .GAP(2)) dut_g (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready_g),
        .start(start), .valid(valid_g), .instruction(instruction_g), .probe(probe),
        .result_valid(result_valid_g), .result_probe(result_probe_g),
        .issued_cnt(issued_cnt_g), .busy(busy_g), .done(done_g)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_word(input logic [7:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0; probe = '0;
        settle(5);
        check("rst_valid",   valid, 0);
        check("rst_instr",   instruction, 8'h00);
        check("rst_ready",   load_ready, 1);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_cnt",     issued_cnt, 0);
        check("rst_rvalid",  result_valid, 0);
        check("rst_rprobe",  result_probe, 8'h00);
        reset = 1'b0;
        tick();

        // single word
        load_word(8'h8c);
        pulse_start();
        check("t1_valid", valid, 1);
        check("t1_instr", instruction, 8'h8c);
        check("t1_busy",  busy, 1);
        probe = 8'h5a;
        tick();
        check("t1_valid_off", valid, 0);
        check("t1_instr_off", instruction, 8'h00);
        check("t1_rvalid", result_valid, 1);
        check("t1_rprobe", result_probe, 8'h5a);
        check("t1_done",   done, 1);
        check("t1_cnt",    issued_cnt, 1);
        tick();
        check("t1_done_off", done, 0);
        check("t1_rvalid_off", result_valid, 0);
        check("t1_rprobe_hold", result_probe, 8'h5a);
        settle(12);

        // three back-to-back words
        load_word(8'h80); load_word(8'h81); load_word(8'h82);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            check("t2_valid", valid, 1);
            check("t2_instr", instruction, 32'h80 + i);
            check("t2_done_early", done, 0);
            probe = 8'h10 + 8'(i);
            tick();
            check("t2_rvalid", result_valid, 1);
            check("t2_rprobe", result_probe, 32'h10 + i);
        end
        check("t2_done", done, 1);
        check("t2_cnt",  issued_cnt, 3);
        tick();
        check("t2_done_once", done, 0);
        check("t2_idle", valid, 0);
        settle(12);

        // GAP=2 pattern on the second instance
        load_word(8'ha0); load_word(8'ha1);
        pulse_start();
        begin
            logic exp_v [5]  = '{1, 0, 0, 1, 0};
            logic exp_d [5]  = '{0, 0, 0, 0, 1};
            logic exp_b [5]  = '{1, 1, 1, 1, 0};
            logic exp_rv [5] = '{0, 1, 0, 0, 1};
            for (int c = 0; c < 5; c++) begin
                check("t3_valid", valid_g, exp_v[c]);
                check("t3_done",  done_g, exp_d[c]);
                check("t3_busy",  busy_g, exp_b[c]);
                check("t3_rvalid", result_valid_g, exp_rv[c]);
                if (c == 0) check("t3_instr0", instruction_g, 8'ha0);
                if (c == 3) check("t3_instr1", instruction_g, 8'ha1);
                if (c == 1) check("t3_gap_instr", instruction_g, 8'h00);
                tick();
            end
        end
        check("t3_cnt", issued_cnt_g, 2);
        settle(12);

        // fill to DEPTH
        for (int i = 0; i < 16; i++) begin
            check("t4_ready", load_ready, 1);
            load_word(8'h40 + 8'(i));
        end
        check("t4_full", load_ready, 0);
        load_word(8'hff);
        check("t4_full_hold", load_ready, 0);
        pulse_start();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid) begin
                check("t4_instr", instruction, 32'h40 + n);
                n++;
            end
            if (done) break;
            tick();
        end
        check("t4_issues", n, 16);
        check("t4_cnt", issued_cnt, 16);
        check("t4_done_seen", done, 1);
        settle(60);

        // empty start, then start with same-cycle load
        pulse_start();
        check("t5_empty_valid", valid, 0);
        check("t5_empty_busy",  busy, 0);
        tick();
        check("t5_empty_busy2", busy, 0);
        load_valid = 1'b1; load_data = 8'h90; start = 1'b1;
        tick();
        load_valid = 1'b0; start = 1'b0;
        check("t5_valid", valid, 1);
        check("t5_instr", instruction, 8'h90);
        tick();
        check("t5_done", done, 1);
        check("t5_cnt",  issued_cnt, 1);
        tick();
        check("t5_single", valid, 0);
        settle(12);

        // reset during the third of five issues
        for (int i = 0; i < 5; i++) load_word(8'hc0 + 8'(i));
        pulse_start();
        tick(); tick();
        check("t6_third_instr", instruction, 8'hc2);
        check("t6_third_cnt", issued_cnt, 2);
        reset = 1'b1;
        #1;
        check("t6_valid", valid, 0);
        check("t6_instr", instruction, 8'h00);
        check("t6_ready", load_ready, 1);
        check("t6_cnt",   issued_cnt, 0);
        check("t6_busy",  busy, 0);
        tick();
        reset = 1'b0;
        tick();
        pulse_start();
        check("t6_discarded", valid, 0);
        check("t6_discarded_g", valid_g, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_instr_issuer.md
GB_INSTR_ISSUER -- requirements
Module: gb_instr_issuer

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set program buffer depth in instructions (power of two, 2..256).
REQ-002 Parameter GAP, default 0, SHALL set idle cycles inserted between consecutive issued instructions (0..15).
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high; clears all state immediately.
REQ-005 load_valid  input  1  SHALL qualify load_data as a program word to append.
REQ-006 load_data  input  8  SHALL carry the opcode byte to append.
REQ-007 load_ready  output  1  SHALL be high when a load is accepted (state IDLE and buffer not full).
REQ-008 start  input  1  SHALL request execution of the buffered program; sampled only in IDLE.
REQ-009 valid  output  1  SHALL qualify instruction toward the processor for exactly one cycle per instruction.
REQ-010 instruction  output  8  SHALL carry the issued opcode; 8'h00 whenever valid is low.
REQ-011 probe  input  8  SHALL be the processor probe value.
REQ-012 result_valid  output  1  SHALL pulse one cycle when result_probe updates.
REQ-013 result_probe  output  8  SHALL hold the probe sampled after the latest issued instruction.
REQ-014 issued_cnt  output  $clog2(DEPTH)+1  SHALL count instructions issued in the current run.
REQ-015 busy  output  1  SHALL be high in states ISSUE and GAP.
REQ-016 done  output  1  SHALL pulse one cycle when the last instruction's result is captured.

Function
REQ-017 States SHALL be IDLE, ISSUE, GAP, DRAIN; encoding is free.
REQ-018 IDLE: load beat (load_valid & load_ready) SHALL write load_data at write pointer and increment count.
REQ-019 IDLE: start with count>0 SHALL go to ISSUE next cycle, clear issued_cnt; start with count==0 SHALL stay IDLE, no output change.
REQ-020 Simultaneous start and load_valid in IDLE: the load SHALL be accepted first and included in the run.
REQ-021 ISSUE: valid=1, instruction=buffer[read pointer] for one cycle; read pointer, issued_cnt increment, count decrements.
REQ-022 After ISSUE: if count reaches 0 go to DRAIN; else go to GAP when GAP>0, else remain in ISSUE (back-to-back beats).
REQ-023 GAP: valid=0 for exactly GAP cycles, then ISSUE.
REQ-024 Probe capture: on the cycle after every ISSUE cycle, result_probe<=probe and result_valid=1.
REQ-025 DRAIN: lasts one cycle (capture of final probe), asserts done, returns to IDLE.
REQ-026 Pointers SHALL wrap modulo DEPTH; buffer full at count==DEPTH drops load_ready; load_valid while not ready SHALL be ignored.
REQ-027 start outside IDLE and load_valid outside IDLE SHALL be ignored.
REQ-028 Buffer contents are consumed by a run; a new run requires reloading.

Reset
REQ-029 On reset: state IDLE, pointers and count 0, valid 0, instruction 8'h00, result_valid 0, result_probe 8'h00, issued_cnt 0, busy 0, done 0, load_ready 1.
REQ-030 Reset mid-run SHALL abort immediately: valid drops asynchronously, buffered program discarded.
REQ-031 Buffer storage itself need not be reset.

Verification
REQ-032 Reset 5 cycles, load 8'h8c, start, GAP=0 -> valid=1 instruction=8'h8c one cycle, result_valid next cycle with probe value, done same cycle, issued_cnt=1.
REQ-033 Load 8'h80,8'h81,8'h82, start, GAP=0 -> three consecutive valid cycles in order, three result_valid pulses, done once.
REQ-034 GAP=2, load two words, start -> valid pattern 1,0,0,1; done one cycle after second valid.
REQ-035 Load DEPTH words -> load_ready low; extra load_valid ignored; run issues exactly DEPTH words, issued_cnt=DEPTH.
REQ-036 start with empty buffer -> no valid, busy stays 0; start with same-cycle load of 8'h90 -> single issue of 8'h90.
REQ-037 Assert reset during third of five issues -> valid 0 immediately, state IDLE, load_ready 1, issued_cnt 0.
